// File: rtl/w_control_unit.sv
// Hard-wired fetch/decode/execute sequencer for the 8-bit single-accumulator machine.
// State is registered; strobes are decoded from the current state (DEC/EX also look at ir/acc).
module w_control_unit #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              run,
  input  logic [DATA_W-1:0] ir,
  input  logic [DATA_W-1:0] acc,
  output logic              pc_out,
  output logic              pc_inc,
  output logic              pc_load,
  output logic              ir_out,
  output logic              ir_load,
  output logic              ar_load,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic              alu_add,
  output logic              alu_sub,
  output logic              alu_write,
  output logic              alu_read,
  output logic              busy,
  output logic              halted,
  output logic [CNT_W-1:0]  instr_count,
  output logic [2:0]        state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_F0   = 3'd1,
    S_F1   = 3'd2,
    S_DEC  = 3'd3,
    S_EX   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  localparam logic [2:0] OP_STOP  = 3'b000;
  localparam logic [2:0] OP_ADD   = 3'b001;
  localparam logic [2:0] OP_SUB   = 3'b010;
  localparam logic [2:0] OP_LOAD  = 3'b011;
  localparam logic [2:0] OP_STORE = 3'b100;
  localparam logic [2:0] OP_JUMP  = 3'b101;
  localparam logic [2:0] OP_JNEG  = 3'b110;
  localparam logic [2:0] OP_JZERO = 3'b111;

  state_t     cur;
  state_t     after_instr;
  logic [2:0] opcode;
  logic       is_jump;
  logic       jump_taken;
  logic       unused_addr;

  assign opcode      = ir[DATA_W-1:ADDR_W];
  assign unused_addr = ^ir[ADDR_W-1:0];
  assign is_jump     = (opcode == OP_JUMP) || (opcode == OP_JNEG) || (opcode == OP_JZERO);
  assign jump_taken  = (opcode == OP_JUMP)
                    || ((opcode == OP_JNEG) && acc[DATA_W-1])
                    || ((opcode == OP_JZERO) && (acc == '0));
  // A run drop only takes effect once the current instruction retires.
  assign after_instr = run ? S_F0 : S_IDLE;

  always_ff @(posedge CLK) begin
    if (RST) begin
      cur         <= S_IDLE;
      instr_count <= '0;
    end else begin
      case (cur)
        S_IDLE: if (run) cur <= S_F0;
        S_F0:   cur <= S_F1;
        S_F1:   cur <= S_DEC;
        S_DEC: begin
          if (opcode == OP_STOP) begin
            cur         <= S_HALT;
            instr_count <= instr_count + 1'b1;
          end else if (is_jump) begin
            cur         <= after_instr;
            instr_count <= instr_count + 1'b1;
          end else begin
            cur <= S_EX;
          end
        end
        S_EX: begin
          cur         <= after_instr;
          instr_count <= instr_count + 1'b1;
        end
        S_HALT: if (!run) cur <= S_IDLE;
        default: cur <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    pc_out    = 1'b0;
    pc_inc    = 1'b0;
    pc_load   = 1'b0;
    ir_out    = 1'b0;
    ir_load   = 1'b0;
    ar_load   = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    alu_add   = 1'b0;
    alu_sub   = 1'b0;
    alu_write = 1'b0;
    alu_read  = 1'b0;
    case (cur)
      S_F0: begin
        pc_out  = 1'b1;
        ar_load = 1'b1;
      end
      S_F1: begin
        mem_rd  = 1'b1;
        ir_load = 1'b1;
        pc_inc  = 1'b1;
      end
      S_DEC: begin
        if (jump_taken) begin
          ir_out  = 1'b1;
          pc_load = 1'b1;
        end else if (!is_jump && (opcode != OP_STOP)) begin
          ir_out  = 1'b1;
          ar_load = 1'b1;
        end
      end
      S_EX: begin
        case (opcode)
          OP_ADD: begin
            mem_rd    = 1'b1;
            alu_add   = 1'b1;
            alu_write = 1'b1;
          end
          OP_SUB: begin
            mem_rd    = 1'b1;
            alu_sub   = 1'b1;
            alu_write = 1'b1;
          end
          OP_LOAD: begin
            mem_rd    = 1'b1;
            alu_write = 1'b1;
          end
          OP_STORE: begin
            alu_read = 1'b1;
            mem_wr   = 1'b1;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign state  = cur;
  assign busy   = (cur != S_IDLE) && (cur != S_HALT);
  assign halted = (cur == S_HALT);

endmodule

// File: tb/tb_w_control_unit.sv
// Bench for w_control_unit: directed cycle-by-cycle vectors with a per-cycle expected queue,
// plus a random ir/acc stream watched by an exclusivity checker.
module tb_w_control_unit;

  logic        CLK;
  logic        RST;
  logic        run;
  logic [7:0]  ir;
  logic [7:0]  acc;
  logic        pc_out, pc_inc, pc_load, ir_out, ir_load, ar_load;
  logic        mem_rd, mem_wr, alu_add, alu_sub, alu_write, alu_read;
  logic        busy, halted;
  logic [15:0] instr_count;
  logic [2:0]  state;

  w_control_unit #(.DATA_W(8), .ADDR_W(5), .CNT_W(16)) dut (
    .CLK(CLK), .RST(RST), .run(run), .ir(ir), .acc(acc),
    .pc_out(pc_out), .pc_inc(pc_inc), .pc_load(pc_load), .ir_out(ir_out),
    .ir_load(ir_load), .ar_load(ar_load), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .alu_add(alu_add), .alu_sub(alu_sub), .alu_write(alu_write), .alu_read(alu_read),
    .busy(busy), .halted(halted), .instr_count(instr_count), .state(state)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // strobe order: pc_out pc_inc pc_load ir_out ir_load ar_load mem_rd mem_wr alu_add alu_sub alu_write alu_read
  localparam logic [11:0] B_PC_OUT  = 12'h800;
  localparam logic [11:0] B_PC_INC  = 12'h400;
  localparam logic [11:0] B_PC_LOAD = 12'h200;
  localparam logic [11:0] B_IR_OUT  = 12'h100;
  localparam logic [11:0] B_IR_LOAD = 12'h080;
  localparam logic [11:0] B_AR_LOAD = 12'h040;
  localparam logic [11:0] B_MEM_RD  = 12'h020;
  localparam logic [11:0] B_MEM_WR  = 12'h010;
  localparam logic [11:0] B_ADD     = 12'h008;
  localparam logic [11:0] B_SUB     = 12'h004;
  localparam logic [11:0] B_WRITE   = 12'h002;
  localparam logic [11:0] B_READ    = 12'h001;

  localparam logic [11:0] S_NONE = 12'h000;
  localparam logic [11:0] S_F0   = B_PC_OUT | B_AR_LOAD;
  localparam logic [11:0] S_F1   = B_MEM_RD | B_IR_LOAD | B_PC_INC;
  localparam logic [11:0] S_JT   = B_IR_OUT | B_PC_LOAD;
  localparam logic [11:0] S_DA   = B_IR_OUT | B_AR_LOAD;
  localparam logic [11:0] S_ADD  = B_MEM_RD | B_ADD | B_WRITE;
  localparam logic [11:0] S_SUB  = B_MEM_RD | B_SUB | B_WRITE;
  localparam logic [11:0] S_ST   = B_READ | B_MEM_WR;

  localparam logic [2:0] ST_IDLE = 3'd0, ST_F0 = 3'd1, ST_F1 = 3'd2,
                         ST_DEC = 3'd3, ST_EX = 3'd4, ST_HALT = 3'd5;

  // observation vector: {state, strobes, busy, halted, instr_count}
  logic [32:0] exp_q[$];
  int checks;
  int errors;

  function automatic logic [32:0] obs_vec();
    return {state, pc_out, pc_inc, pc_load, ir_out, ir_load, ar_load, mem_rd, mem_wr,
            alu_add, alu_sub, alu_write, alu_read, busy, halted, instr_count};
  endfunction

  // driver: drive inputs for this cycle and push what the DUT must show during it
  task automatic cyc(input logic r, input logic rn, input logic [7:0] i, input logic [7:0] a,
                     input logic [2:0] st, input logic [11:0] sb, input logic [15:0] cnt);
    logic b, h;
    @(posedge CLK);
    #1;
    RST = r;
    run = rn;
    ir  = i;
    acc = a;
    b = (st != ST_IDLE) && (st != ST_HALT);
    h = (st == ST_HALT);
    exp_q.push_back({st, sb, b, h, cnt});
  endtask

  // scoreboard monitor
  initial begin
    logic [32:0] e, g;
    forever begin
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        g = obs_vec();
        checks++;
        if (g !== e) begin
          errors++;
          $display("FAIL seq t=%0t state got %0d exp %0d strobes got %03h exp %03h busy/halted got %b%b exp %b%b count got %0d exp %0d",
                   $time, g[32:30], e[32:30], g[29:18], e[29:18], g[17], g[16], e[17], e[16],
                   g[15:0], e[15:0]);
        end
      end
    end
  end

  // exclusivity checker, every cycle
  initial begin
    forever begin
      @(negedge CLK);
      checks++;
      if ((mem_rd && alu_read) || (pc_out && ir_out) || (alu_add && alu_sub) || (mem_wr && mem_rd)) begin
        errors++;
        $display("FAIL excl t=%0t got rd/read=%b%b pcout/irout=%b%b add/sub=%b%b wr/rd=%b%b exp no pair both 1",
                 $time, mem_rd, alu_read, pc_out, ir_out, alu_add, alu_sub, mem_wr, mem_rd);
      end
    end
  end

  initial begin
    RST = 1'b1;
    run = 1'b0;
    ir  = 8'h00;
    acc = 8'h00;
    checks = 0;
    errors = 0;
    repeat (2) @(posedge CLK);

    // ADD @5: reset state, then F0 F1 DEC EX, back to F0 with count 1
    cyc(0, 1, 8'h25, 8'h00, ST_IDLE, S_NONE, 0);
    cyc(0, 1, 8'h25, 8'h00, ST_F0,   S_F0,   0);
    cyc(0, 1, 8'h25, 8'h00, ST_F1,   S_F1,   0);
    cyc(0, 1, 8'h25, 8'h00, ST_DEC,  S_DA,   0);
    cyc(0, 1, 8'h25, 8'h00, ST_EX,   S_ADD,  0);
    // STORE @5 twice
    cyc(0, 1, 8'h85, 8'h00, ST_F0,   S_F0,   1);
    cyc(0, 1, 8'h85, 8'h00, ST_F1,   S_F1,   1);
    cyc(0, 1, 8'h85, 8'h00, ST_DEC,  S_DA,   1);
    cyc(0, 1, 8'h85, 8'h00, ST_EX,   S_ST,   1);
    cyc(0, 1, 8'h85, 8'h00, ST_F0,   S_F0,   2);
    cyc(0, 1, 8'h85, 8'h00, ST_F1,   S_F1,   2);
    cyc(0, 1, 8'h85, 8'h00, ST_DEC,  S_DA,   2);
    cyc(0, 1, 8'h85, 8'h00, ST_EX,   S_ST,   2);
    // JNEG taken (acc=0x80)
    cyc(0, 1, 8'hC3, 8'h80, ST_F0,   S_F0,   3);
    cyc(0, 1, 8'hC3, 8'h80, ST_F1,   S_F1,   3);
    cyc(0, 1, 8'hC3, 8'h80, ST_DEC,  S_JT,   3);
    // JNEG not taken (acc=0x7F)
    cyc(0, 1, 8'hC3, 8'h7F, ST_F0,   S_F0,   4);
    cyc(0, 1, 8'hC3, 8'h7F, ST_F1,   S_F1,   4);
    cyc(0, 1, 8'hC3, 8'h7F, ST_DEC,  S_NONE, 4);
    // JZERO taken (acc=0x00)
    cyc(0, 1, 8'hE3, 8'h00, ST_F0,   S_F0,   5);
    cyc(0, 1, 8'hE3, 8'h00, ST_F1,   S_F1,   5);
    cyc(0, 1, 8'hE3, 8'h00, ST_DEC,  S_JT,   5);
    // STOP: HALT held while run=1, IDLE after run drops
    cyc(0, 1, 8'h00, 8'h00, ST_F0,   S_F0,   6);
    cyc(0, 1, 8'h00, 8'h00, ST_F1,   S_F1,   6);
    cyc(0, 1, 8'h00, 8'h00, ST_DEC,  S_NONE, 6);
    cyc(0, 1, 8'h00, 8'h00, ST_HALT, S_NONE, 7);
    cyc(0, 1, 8'h00, 8'h00, ST_HALT, S_NONE, 7);
    cyc(0, 0, 8'h00, 8'h00, ST_HALT, S_NONE, 7);
    // SUB with run dropped in F1: completes, then IDLE
    cyc(0, 1, 8'h45, 8'h00, ST_IDLE, S_NONE, 7);
    cyc(0, 1, 8'h45, 8'h00, ST_F0,   S_F0,   7);
    cyc(0, 0, 8'h45, 8'h00, ST_F1,   S_F1,   7);
    cyc(0, 0, 8'h45, 8'h00, ST_DEC,  S_DA,   7);
    cyc(0, 0, 8'h45, 8'h00, ST_EX,   S_SUB,  7);
    // ADD interrupted by reset in EX
    cyc(0, 1, 8'h25, 8'h00, ST_IDLE, S_NONE, 8);
    cyc(0, 1, 8'h25, 8'h00, ST_F0,   S_F0,   8);
    cyc(0, 1, 8'h25, 8'h00, ST_F1,   S_F1,   8);
    cyc(0, 1, 8'h25, 8'h00, ST_DEC,  S_DA,   8);
    cyc(1, 0, 8'h25, 8'h00, ST_EX,   S_ADD,  8);
    cyc(0, 0, 8'h25, 8'h00, ST_IDLE, S_NONE, 0);
    cyc(0, 0, 8'h25, 8'h00, ST_IDLE, S_NONE, 0);

    // drain the expected queue with a bounded wait
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge CLK);
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain got %0d pending exp 0", exp_q.size());
    end

    // random ir/acc stream for the exclusivity checker
    for (int n = 0; n < 400; n++) begin
      @(posedge CLK);
      #1;
      RST = (n == 200);
      run = ($urandom_range(0, 9) != 0);
      ir  = 8'($urandom_range(0, 255));
      acc = 8'($urandom_range(0, 255));
    end

    @(negedge CLK);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
